ripple_carry_adder8: RTL and testbench

//   Parameterised binary adder: sum = a + b + cin, built as a true ripple chain of 1-bit full adders.

---
 rtl/ripple_carry_adder8_pkg.sv | 13 +
 rtl/ripple_carry_adder8_full_adder.sv | 16 +
 rtl/ripple_carry_adder8.sv | 64 ++++++
 tb/tb_ripple_carry_adder8.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ripple_carry_adder8_pkg.sv
// Shared definitions for the ripple-carry adder slice.
// Holds the default operand width and the signed-overflow helper.
package ripple_carry_adder8_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Signed overflow occurs when the carry into the MSB differs from the carry out of it.
  function automatic logic signed_overflow(input logic carry_into_msb,
                                           input logic carry_out_msb);
    return carry_into_msb ^ carry_out_msb;
  endfunction

endpackage

// File: rtl/ripple_carry_adder8_full_adder.sv
// Single-bit full adder: the leaf cell of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder8.sv
// Ripple-carry adder built from explicit full_adder cells.
// The output register captures sum, carry-out and the signed-overflow flag.
module ripple_carry_adder8
  import ripple_carry_adder8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  // Each stage keeps its own carry wires so the chain never feeds back through one vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci_w;
    logic co_w;

    if (i == 0) begin : g_first
      assign ci_w = cin;
    end else begin : g_rest
      assign ci_w = g_bit[i-1].co_w;
    end

    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (ci_w),
      .s  (s[i]),
      .co (co_w)
    );

    assign c[i+1] = co_w;
  end

  // Reset wins over a same-cycle operation; idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= s;
        cout     <= c[WIDTH];
        overflow <= signed_overflow(c[WIDTH-1], c[WIDTH]);
      end
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder8.sv
// Self-checking bench for ripple_carry_adder8 (WIDTH=8).
// Directed vectors with hand-computed results, reset and hold cases, then random vectors.
module tb_ripple_carry_adder8;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;

  int testsRun;
  int testsFailed;

  ripple_carry_adder8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] va;
    logic [7:0] vb;
    logic       vcin;
    logic [7:0] expSum;
    logic       expCout;
    logic       expOv;
  } vector_t;

  vector_t directed[6];

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; results are read on the following falling edge.
  task automatic applyStimulus(input logic valid, input logic reset,
                               input logic [7:0] va, input logic [7:0] vb,
                               input logic vcin);
    @(negedge clk);
    in_valid = valid;
    rst      = reset;
    a        = va;
    b        = vb;
    cin      = vcin;
    @(negedge clk);
  endtask

  task automatic checkResult(input string tag, input logic expValid,
                             input logic [7:0] expSum, input logic expCout,
                             input logic expOv);
    checkOutput({tag, "_valid"}, {15'd0, out_valid}, {15'd0, expValid});
    checkOutput({tag, "_sum"},   {8'd0, sum},        {8'd0, expSum});
    checkOutput({tag, "_cout"},  {15'd0, cout},      {15'd0, expCout});
    checkOutput({tag, "_ovf"},   {15'd0, overflow},  {15'd0, expOv});
  endtask

  initial begin
    logic [8:0] full;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic       expOv;

    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    a           = 8'h00;
    b           = 8'h00;
    cin         = 1'b0;

    directed[0] = '{"inc",     8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    directed[1] = '{"ripple4", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    directed[2] = '{"wrap",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    directed[3] = '{"cinwrap", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    directed[4] = '{"posovf",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    directed[5] = '{"negovf",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResult("reset", 1'b0, 8'h00, 1'b0, 1'b0);

    foreach (directed[i]) begin
      applyStimulus(1'b1, 1'b0, directed[i].va, directed[i].vb, directed[i].vcin);
      checkResult(directed[i].tag, 1'b1, directed[i].expSum, directed[i].expCout,
                  directed[i].expOv);
    end

    // Idle cycle: valid drops, last result (0x80+0x80) is held.
    applyStimulus(1'b0, 1'b0, 8'h12, 8'h34, 1'b1);
    checkResult("hold", 1'b0, 8'h00, 1'b1, 1'b1);

    applyStimulus(1'b1, 1'b0, 8'h12, 8'h34, 1'b1);
    checkResult("pre_rst", 1'b1, 8'h47, 1'b0, 1'b0);

    // Reset pulsed mid-stream drops the operation presented with it.
    applyStimulus(1'b1, 1'b1, 8'h7F, 8'h7F, 1'b1);
    checkResult("mid_rst", 1'b0, 8'h00, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 8'hC0, 8'h50, 1'b0);
    checkResult("post_rst", 1'b1, 8'h10, 1'b1, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra    = 8'($urandom_range(0, 255));
      rb    = 8'($urandom_range(0, 255));
      rc    = 1'($urandom_range(0, 1));
      full  = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      expOv = (ra[7] == rb[7]) && (full[7] != ra[7]);
      applyStimulus(1'b1, 1'b0, ra, rb, rc);
      checkResult("rand", 1'b1, full[7:0], full[8], expOv);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
